// File: rtl/rx_fsm.sv
// rx_fsm: serial word receiver with 2-FF synchronisers, length check and inactivity timeout.
module rx_fsm #(
  parameter int DATA_WIDTH_BASE = 5,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_en,
  input  logic                            sck_rx,
  input  logic                            data_rx,
  input  logic                            latch_rx,
  output logic [2**DATA_WIDTH_BASE-1:0]   rx_data,
  output logic                            rx_valid,
  output logic                            rx_error,
  output logic                            busy
);
  localparam int W  = 2**DATA_WIDTH_BASE;
  localparam int CW = DATA_WIDTH_BASE + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(W + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [2:0]    meta_q, sync_q;
  logic [1:0]    hist_q;
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  shift_q, shift_d, rx_data_q, rx_data_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic          rx_valid_q, rx_valid_d, rx_error_q, rx_error_d, busy_q, busy_d;
  logic          sck_s, data_s, latch_s, sck_rise, latch_rise;

  // All three link inputs share one synchroniser depth so data stays aligned with sck.
  assign sck_s      = sync_q[0];
  assign data_s     = sync_q[1];
  assign latch_s    = sync_q[2];
  assign sck_rise   = sck_s & ~hist_q[0];
  assign latch_rise = latch_s & ~hist_q[1];
  assign cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  assign tmo_inc    = tmo_q + 1'b1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    if (state_q == IDLE) begin
      shift_d = '0;
      cnt_d   = '0;
      tmo_d   = '0;
      if (sck_rise) begin
        state_d = RECV;
        shift_d = {{(W-1){1'b0}}, data_s};
        cnt_d   = CW'(1);
      end
    end else if (state_q == RECV) begin
      shift_d = sck_rise ? {shift_q[W-2:0], data_s} : shift_q;
      cnt_d   = sck_rise ? cnt_inc : cnt_q;
      tmo_d   = sck_rise ? '0 : tmo_inc;
      // A same-cycle bit is counted before the length check.
      if (latch_rise) state_d = (cnt_d == CNT_FULL) ? DONE : ERR;
      else if (!sck_rise && tmo_inc == TMO_LAST) state_d = ERR;
    end else begin
      state_d = IDLE;
    end
    if (!rx_en) state_d = IDLE;
  end

  always_comb begin
    rx_valid_d = state_q == DONE;
    rx_error_d = state_q == ERR;
    rx_data_d  = rx_valid_d ? shift_q : rx_data_q;
    busy_d     = state_d == RECV;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q     <= '0;
      sync_q     <= '0;
      hist_q     <= '0;
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      meta_q     <= {latch_rx, data_rx, sck_rx};
      sync_q     <= meta_q;
      hist_q     <= {latch_s, sck_s};
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_error = rx_error_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_rx_fsm.sv
// tb_rx_fsm: directed bench for rx_fsm with a 16-cycle timeout.
module tb_rx_fsm;
  logic clk = 0, rst = 0, rx_en = 0, sck_rx = 0, data_rx = 0, latch_rx = 0;
  logic [31:0] rx_data;
  logic rx_valid, rx_error, busy;
  int checks = 0, failures = 0, nv = 0, ne = 0, nv0, ne0;

  rx_fsm #(.DATA_WIDTH_BASE(5), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .sck_rx(sck_rx), .data_rx(data_rx),
    .latch_rx(latch_rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_error(rx_error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) nv++;
    if (rx_error) ne++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic b);
    data_rx = b;
    sck_rx = 1;
    tick(3);
    sck_rx = 0;
    tick(3);
  endtask

  task automatic send(input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) pulse(v[k]);
  endtask

  task automatic latch_check(input string tag, input logic v, input logic e, input logic [31:0] d);
    latch_rx = 1;
    tick(2);
    latch_rx = 0;
    tick(1);
    chk({tag, "_early"}, {30'b0, rx_valid, rx_error}, 32'd0);
    tick(1);
    chk({tag, "_valid"}, rx_valid, v);
    chk({tag, "_error"}, rx_error, e);
    chk({tag, "_data"}, rx_data, d);
    tick(1);
    chk({tag, "_after"}, {30'b0, rx_valid, rx_error}, 32'd0);
    tick(6);
  endtask

  initial begin
    tick(2);
    chk("rst_data", rx_data, 32'd0);
    chk("rst_flags", {29'b0, rx_valid, rx_error, busy}, 32'd0);
    rst = 1;
    rx_en = 1;
    tick(2);

    send(64'hA5C3_0F96, 32);
    chk("w0_busy", busy, 1'b1);
    latch_check("w0", 1'b1, 1'b0, 32'hA5C3_0F96);
    chk("w0_noerr", ne, 0);

    send(64'hFFFF_FFFF, 32);
    latch_check("w1", 1'b1, 1'b0, 32'hFFFF_FFFF);
    send(64'h0000_0001, 32);
    latch_check("w2", 1'b1, 1'b0, 32'h0000_0001);

    send(64'h7FFF_FFFF, 31);
    latch_check("short", 1'b0, 1'b1, 32'h0000_0001);

    send(64'h1_2345_6789, 33);
    latch_check("long", 1'b0, 1'b1, 32'h0000_0001);
    send(64'h1234_5678, 32);
    latch_check("w3", 1'b1, 1'b0, 32'h1234_5678);

    send(64'h155, 9);
    data_rx = 1;
    sck_rx = 1;
    for (int k = 1; k <= 19; k++) begin
      tick(1);
      if (k == 3) sck_rx = 0;
      if (k == 17) chk("tmo_busy", busy, 1'b1);
      if (k == 18) chk("tmo_quiet", rx_error, 1'b0);
      if (k == 19) begin
        chk("tmo_error", rx_error, 1'b1);
        chk("tmo_busy_fall", busy, 1'b0);
        chk("tmo_data", rx_data, 32'h1234_5678);
      end
    end
    tick(1);
    chk("tmo_after", rx_error, 1'b0);
    tick(6);
    send(64'hCAFE_F00D, 32);
    latch_check("w4", 1'b1, 1'b0, 32'hCAFE_F00D);

    send(64'h5A5A, 16);
    data_rx = 1;
    sck_rx = 1;
    tick(3);
    chk("mid_busy", busy, 1'b1);
    rst = 0;
    #1;
    chk("arst_data", rx_data, 32'd0);
    chk("arst_flags", {29'b0, rx_valid, rx_error, busy}, 32'd0);
    sck_rx = 0;
    tick(2);
    rst = 1;
    tick(3);
    send(64'hDEAD_BEEF, 32);
    latch_check("w5", 1'b1, 1'b0, 32'hDEAD_BEEF);

    send(64'hABC, 12);
    chk("en_busy", busy, 1'b1);
    nv0 = nv;
    ne0 = ne;
    rx_en = 0;
    tick(1);
    chk("en_idle", busy, 1'b0);
    tick(2);
    rx_en = 1;
    latch_rx = 1;
    tick(2);
    latch_rx = 0;
    tick(6);
    chk("en_nostrobe", nv - nv0 + ne - ne0, 0);
    chk("en_keep", rx_data, 32'hDEAD_BEEF);
    send(64'h0F0F_0F0F, 32);
    latch_check("w6", 1'b1, 1'b0, 32'h0F0F_0F0F);

    chk("total_valid", nv, 7);
    chk("total_error", ne, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
